// File: rtl/dmem_port_arbiter_if.sv
// Bundles the MEM-stage, auxiliary and data-memory signals of the data-memory port arbiter.
// The arbiter uses the slave modport; the surrounding pipeline, auxiliary master and memory use master.
interface dmem_port_arbiter_if;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [31:0] addr_MEM;
  logic [31:0] wdata_MEM;
  logic [31:0] rdata_MEM;
  logic        stall_MEM;

  logic        req_AUX;
  logic        we_AUX;
  logic [31:0] addr_AUX;
  logic [31:0] wdata_AUX;
  logic        gnt_AUX;
  logic        rvalid_AUX;
  logic [31:0] rdata_AUX;

  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [31:0] data_read_fDM;

  modport slave (
    input  MemRead_MEM, MemWrite_MEM, addr_MEM, wdata_MEM,
    output rdata_MEM, stall_MEM,
    input  req_AUX, we_AUX, addr_AUX, wdata_AUX,
    output gnt_AUX, rvalid_AUX, rdata_AUX,
    output MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_2DM,
    input  data_read_fDM
  );

  modport master (
    output MemRead_MEM, MemWrite_MEM, addr_MEM, wdata_MEM,
    input  rdata_MEM, stall_MEM,
    output req_AUX, we_AUX, addr_AUX, wdata_AUX,
    input  gnt_AUX, rvalid_AUX, rdata_AUX,
    input  MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_2DM,
    output data_read_fDM
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the MEM pipeline stage (priority) and an auxiliary master,
// with fixed memory latency and bounded AUX starvation. Define DMEM_ARB_PERF_EN for perf counters.
module dmem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_aux_cnt,
`endif
  dmem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWNER_MEM = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  localparam logic [3:0] WAIT_INIT  = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        cmd_write_q, cmd_write_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic mem_req;
  logic grant_aux;
  logic grant_mem;
  logic in_access;
  logic stall;

  // Grants are gated by RESET so every output reads 0 while reset is held.
  always_comb begin
    mem_req   = bus.MemRead_MEM | bus.MemWrite_MEM;
    grant_aux = RESET && (state_q == ST_IDLE) && bus.req_AUX &&
                (!mem_req || (starve_cnt_q == STARVE_MAX));
    grant_mem = RESET && (state_q == ST_IDLE) && !grant_aux && mem_req;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_aux) begin
          owner_d      = OWNER_AUX;
          cmd_write_d  = bus.we_AUX;
          cmd_addr_d   = bus.addr_AUX;
          cmd_wdata_d  = bus.wdata_AUX;
          starve_cnt_d = 4'd0;
          wait_cnt_d   = WAIT_INIT;
          state_d      = ST_ACCESS;
        end else if (grant_mem) begin
          owner_d     = OWNER_MEM;
          cmd_write_d = bus.MemWrite_MEM;
          cmd_addr_d  = bus.addr_MEM;
          cmd_wdata_d = bus.wdata_MEM;
          if (bus.req_AUX && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
          wait_cnt_d = WAIT_INIT;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_q == 4'd0) begin
          if (!cmd_write_q) begin
            rdata_d = bus.data_read_fDM;
          end
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_MEM;
      starve_cnt_q <= 4'd0;
      wait_cnt_q   <= 4'd0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= 32'd0;
      cmd_wdata_q  <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign stall     = RESET && mem_req && !((state_q == ST_RESP) && (owner_q == OWNER_MEM));

  assign bus.MemRead_2DM      = in_access && !cmd_write_q;
  assign bus.MemWrite_2DM     = in_access && cmd_write_q;
  assign bus.data_address_2DM = in_access ? cmd_addr_q  : 32'd0;
  assign bus.data_write_2DM   = in_access ? cmd_wdata_q : 32'd0;
  assign bus.gnt_AUX          = grant_aux;
  assign bus.rvalid_AUX       = (state_q == ST_RESP) && (owner_q == OWNER_AUX);
  assign bus.stall_MEM        = stall;
  assign bus.rdata_MEM        = rdata_q;
  assign bus.rdata_AUX        = rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_aux_q, perf_aux_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall};
    perf_aux_d   = perf_aux_q + {31'd0, grant_aux};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      perf_stall_q <= 32'd0;
      perf_aux_q   <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_aux_q   <= perf_aux_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_aux_cnt   = perf_aux_q;
`else
  // Perf counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed-plus-random bench for dmem_port_arbiter; the bench plays the data memory and keeps a
// word-level reference copy of it. Define DMEM_ARB_PERF_EN to also check the perf counters.
module tb_dmem_port_arbiter;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int testCount = 0;
  int failCount = 0;

  logic [31:0] refMem [int];
  logic [31:0] lastRead = 32'd0;
  logic [31:0] envMem [256];
  bit          envValid [256];

  dmem_port_arbiter_if bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_aux_cnt;
`endif

  dmem_port_arbiter #(
    .MEM_LATENCY  (MEM_LATENCY),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_aux_cnt   (perf_aux_cnt),
`endif
    .bus            (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] seedWord(input logic [7:0] idx);
    return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
  endfunction

  // Memory seen by the DUT: seeded contents, overwritten by write strobes at each clock edge.
  assign bus.data_read_fDM = envValid[bus.data_address_2DM[9:2]] ?
                             envMem[bus.data_address_2DM[9:2]] : seedWord(bus.data_address_2DM[9:2]);

  always @(posedge CLK) begin
    if (bus.MemWrite_2DM) begin
      envMem[bus.data_address_2DM[9:2]]   <= bus.data_write_2DM;
      envValid[bus.data_address_2DM[9:2]] <= 1'b1;
    end
  end

  function automatic logic [31:0] refRead(input logic [7:0] idx);
    if (refMem.exists(int'(idx))) return refMem[int'(idx)];
    return seedWord(idx);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.MemRead_MEM  = rd;
    bus.MemWrite_MEM = wr;
    bus.addr_MEM     = addr;
    bus.wdata_MEM    = wdata;
  endtask

  task automatic applyAux(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_AUX   = req;
    bus.we_AUX    = we;
    bus.addr_AUX  = addr;
    bus.wdata_AUX = wdata;
  endtask

  task automatic doReset;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    applyAux(1'b0, 1'b0, 32'd0, 32'd0);
    RESET = 1'b0;
    tick;
    tick;
    RESET = 1'b1;
    lastRead = 32'd0;
  endtask

  task automatic modelAccess(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata);
    if (isWrite) refMem[int'(addr[9:2])] = wdata;
    else lastRead = refRead(addr[9:2]);
  endtask

  // MEM op from an idle arbiter: stall in cycles 0..L, strobes in 1..L, released in L+1.
  task automatic memOp(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata);
    tick;
    applyStimulus(!isWrite, isWrite, addr, wdata);
    modelAccess(isWrite, addr, wdata);
    #1;
    checkOutput("mem_c0_stall", bus.stall_MEM, 1'b1);
    checkOutput("mem_c0_strobes", {bus.MemRead_2DM, bus.MemWrite_2DM}, 2'b00);
    for (int c = 1; c <= MEM_LATENCY; c++) begin
      tick;
      checkOutput("mem_acc_stall", bus.stall_MEM, 1'b1);
      checkOutput("mem_acc_read", bus.MemRead_2DM, !isWrite);
      checkOutput("mem_acc_write", bus.MemWrite_2DM, isWrite);
      checkOutput("mem_acc_addr", bus.data_address_2DM, addr);
      if (isWrite) checkOutput("mem_acc_wdata", bus.data_write_2DM, wdata);
    end
    tick;
    checkOutput("mem_resp_stall", bus.stall_MEM, 1'b0);
    checkOutput("mem_resp_strobes", {bus.MemRead_2DM, bus.MemWrite_2DM}, 2'b00);
    checkOutput("mem_resp_rdata", bus.rdata_MEM, lastRead);
    checkOutput("mem_resp_rvalid_aux", bus.rvalid_AUX, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // AUX op from an idle arbiter: gnt in cycle 0, rvalid in cycle L+1, MEM never stalled.
  task automatic auxOp(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata);
    tick;
    applyAux(1'b1, isWrite, addr, wdata);
    modelAccess(isWrite, addr, wdata);
    #1;
    checkOutput("aux_c0_gnt", bus.gnt_AUX, 1'b1);
    checkOutput("aux_c0_stall", bus.stall_MEM, 1'b0);
    for (int c = 1; c <= MEM_LATENCY; c++) begin
      tick;
      if (c == 1) applyAux(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("aux_acc_gnt", bus.gnt_AUX, 1'b0);
      checkOutput("aux_acc_rvalid", bus.rvalid_AUX, 1'b0);
      checkOutput("aux_acc_strobes", {bus.MemRead_2DM, bus.MemWrite_2DM}, {!isWrite, isWrite});
      checkOutput("aux_acc_addr", bus.data_address_2DM, addr);
      if (isWrite) checkOutput("aux_acc_wdata", bus.data_write_2DM, wdata);
    end
    tick;
    checkOutput("aux_resp_rvalid", bus.rvalid_AUX, 1'b1);
    checkOutput("aux_resp_rdata", bus.rdata_AUX, lastRead);
    checkOutput("aux_resp_stall", bus.stall_MEM, 1'b0);
    tick;
    checkOutput("aux_idle_rvalid", bus.rvalid_AUX, 1'b0);
  endtask

  initial begin
    #100000;
    $fatal(1, "[TB] watchdog expired before the bench finished");
  end

  initial begin
    logic [31:0] addrA, addrB, dataW;
    int memDone, rounds, cyc;

    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    applyAux(1'b0, 1'b0, 32'd0, 32'd0);
    RESET = 1'b0;
    tick;
    tick;
    checkOutput("rst_stall", bus.stall_MEM, 1'b0);
    checkOutput("rst_gnt", bus.gnt_AUX, 1'b0);
    checkOutput("rst_rvalid", bus.rvalid_AUX, 1'b0);
    checkOutput("rst_strobes", {bus.MemRead_2DM, bus.MemWrite_2DM}, 2'b00);
    checkOutput("rst_addr", bus.data_address_2DM, 32'd0);
    checkOutput("rst_wdata", bus.data_write_2DM, 32'd0);
    checkOutput("rst_rdata_mem", bus.rdata_MEM, 32'd0);
    checkOutput("rst_rdata_aux", bus.rdata_AUX, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0);
    applyAux(1'b1, 1'b0, 32'h20, 32'd0);
    #1;
    checkOutput("rst_held_req_gnt", bus.gnt_AUX, 1'b0);
    checkOutput("rst_held_req_stall", bus.stall_MEM, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    applyAux(1'b0, 1'b0, 32'd0, 32'd0);
    RESET = 1'b1;

    // Loader writes the word later fetched by the pipeline, then a fresh reset for counters.
    auxOp(1'b1, 32'h100, 32'hDEADBEEF);
    doReset;
    memOp(1'b0, 32'h100, 32'd0);
    checkOutput("load_deadbeef", bus.rdata_MEM, 32'hDEADBEEF);
    memOp(1'b0, 32'h100, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd6);
    checkOutput("perf_aux_cnt", perf_aux_cnt, 32'd0);
`endif
    memOp(1'b1, 32'h40, 32'h12345678);
    checkOutput("store_keeps_rdata", bus.rdata_MEM, 32'hDEADBEEF);
    memOp(1'b0, 32'h40, 32'd0);
    auxOp(1'b0, 32'h80, 32'd0);
    checkOutput("aux_read_80", bus.rdata_AUX, seedWord(8'd32));

    for (int i = 0; i < 12; i++) begin
      addrA = {22'd0, 8'($urandom_range(0, 7)), 2'b00};
      dataW = $urandom;
      case ($urandom_range(0, 3))
        0: memOp(1'b0, addrA, 32'd0);
        1: memOp(1'b1, addrA, dataW);
        2: auxOp(1'b0, addrA, 32'd0);
        default: auxOp(1'b1, addrA, dataW);
      endcase
    end

    // AUX raised during a MEM access must wait for the next IDLE cycle.
    addrA = 32'h0000_0300;
    addrB = 32'h0000_0304;
    tick;
    applyStimulus(1'b1, 1'b0, addrA, 32'd0);
    modelAccess(1'b0, addrA, 32'd0);
    tick;
    applyAux(1'b1, 1'b0, addrB, 32'd0);
    #1;
    checkOutput("aux_pend_acc1_gnt", bus.gnt_AUX, 1'b0);
    tick;
    checkOutput("aux_pend_acc2_gnt", bus.gnt_AUX, 1'b0);
    tick;
    checkOutput("aux_pend_resp_gnt", bus.gnt_AUX, 1'b0);
    checkOutput("aux_pend_resp_stall", bus.stall_MEM, 1'b0);
    checkOutput("aux_pend_resp_rdata", bus.rdata_MEM, lastRead);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    checkOutput("aux_pend_idle_gnt", bus.gnt_AUX, 1'b1);
    modelAccess(1'b0, addrB, 32'd0);
    tick;
    applyAux(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    tick;
    checkOutput("aux_pend_rvalid", bus.rvalid_AUX, 1'b1);
    checkOutput("aux_pend_rdata", bus.rdata_AUX, lastRead);

    // A store dropped mid-access (flush) still completes and lands in memory.
    addrA = 32'h0000_0200;
    dataW = $urandom;
    tick;
    applyStimulus(1'b0, 1'b1, addrA, dataW);
    modelAccess(1'b1, addrA, dataW);
    tick;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("flush_stall", bus.stall_MEM, 1'b0);
    checkOutput("flush_write_c1", bus.MemWrite_2DM, 1'b1);
    checkOutput("flush_wdata_c1", bus.data_write_2DM, dataW);
    tick;
    checkOutput("flush_write_c2", bus.MemWrite_2DM, 1'b1);
    tick;
    checkOutput("flush_write_resp", bus.MemWrite_2DM, 1'b0);
    memOp(1'b0, addrA, 32'd0);

    // Continuous MEM traffic with a pending AUX: STARVE_LIMIT MEM completions per AUX grant.
    doReset;
    tick;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    applyAux(1'b1, 1'b1, 32'h0000_0014, 32'hCAFEF00D);
    #1;
    memDone = 0;
    rounds = 0;
    cyc = 0;
    while (rounds < 2 && cyc < 200) begin
      if (!bus.stall_MEM) memDone++;
      if (bus.gnt_AUX) begin
        checkOutput("starve_mem_grants", memDone, STARVE_LIMIT);
        memDone = 0;
        rounds++;
      end
      if (rounds < 2) begin
        tick;
        cyc++;
      end
    end
    checkOutput("starve_rounds", rounds, 2);
    applyAux(1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    for (int c = 0; c < MEM_LATENCY + 2; c++) tick;

    // Reset in the middle of an AUX read: outputs clear at once and no completion follows.
    memOp(1'b0, 32'h0000_0104, 32'd0);
    tick;
    applyAux(1'b1, 1'b0, 32'h0000_0108, 32'd0);
    tick;
    applyAux(1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0110, 32'd0);
    #1;
    checkOutput("midrst_pre_read", bus.MemRead_2DM, 1'b1);
    RESET = 1'b0;
    #1;
    checkOutput("midrst_read", bus.MemRead_2DM, 1'b0);
    checkOutput("midrst_addr", bus.data_address_2DM, 32'd0);
    checkOutput("midrst_stall", bus.stall_MEM, 1'b0);
    checkOutput("midrst_rdata", bus.rdata_MEM, 32'd0);
    checkOutput("midrst_rvalid", bus.rvalid_AUX, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    RESET = 1'b1;
    lastRead = 32'd0;
    for (int c = 0; c < MEM_LATENCY + 2; c++) begin
      tick;
      checkOutput("midrst_no_rvalid", bus.rvalid_AUX, 1'b0);
      checkOutput("midrst_no_read", bus.MemRead_2DM, 1'b0);
    end
    memOp(1'b0, 32'h0000_0110, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences and shares the single data-memory port (`*_2DM` / `data_read_fDM`) between two requesters.
- Requester 1 is the MEM pipeline stage, which has priority.
- Requester 2 is an auxiliary port (loader/debug/DMA).
- Handles multi-cycle memory latency, stalls the pipeline until its access completes, and bounds auxiliary starvation with a counter.

Parameters:
- MEM_LATENCY, 2: cycles the `*_2DM` command is held before `data_read_fDM` is sampled; legal range 1..15.
- STARVE_LIMIT, 4: consecutive MEM grants allowed while `req_AUX` is pending before AUX is forced; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MemRead_MEM  in  1  MEM stage load request; held stable while stall_MEM=1.
- MemWrite_MEM  in  1  MEM stage store request; held stable while stall_MEM=1.
- addr_MEM  in  32  MEM stage byte address.
- wdata_MEM  in  32  MEM stage store data.
- rdata_MEM  out  32  load data returned to MEM stage.
- stall_MEM  out  1  freeze pipeline; MEM access not yet complete.
- req_AUX  in  1  auxiliary request; held until gnt_AUX.
- we_AUX  in  1  auxiliary write enable (1=write, 0=read).
- addr_AUX  in  32  auxiliary address.
- wdata_AUX  in  32  auxiliary write data.
- gnt_AUX  out  1  one-cycle pulse: AUX request accepted.
- rvalid_AUX  out  1  one-cycle pulse: AUX access complete; rdata_AUX valid on reads.
- rdata_AUX  out  32  auxiliary read data.
- MemRead_2DM  out  1  data memory read strobe.
- MemWrite_2DM  out  1  data memory write strobe.
- data_address_2DM  out  32  data memory address.
- data_write_2DM  out  32  data memory write data.
- data_read_fDM  in  32  data memory read data.

Behaviour:
- Reset (RESET=0, async): state=IDLE; owner=MEM; starve_cnt=0; wait_cnt=0; all outputs 0; rdata register 0. A reset taken mid-access aborts the access with no completion pulse.
- mem_req = MemRead_MEM | MemWrite_MEM. If both are set, the access is a write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE arbitration, in priority order:
  - req_AUX && (!mem_req || starve_cnt==STARVE_LIMIT): grant AUX. gnt_AUX=1 this cycle (combinational); starve_cnt<=0.
  - else mem_req: grant MEM. starve_cnt<=starve_cnt+1 if req_AUX, else unchanged. starve_cnt saturates at STARVE_LIMIT.
  - Any grant latches owner, address, write data and R/W into command registers; next state is ACCESS with wait_cnt<=MEM_LATENCY-1.
- ACCESS:
  - Drive from command registers: MemRead_2DM=!write, MemWrite_2DM=write, data_address_2DM, data_write_2DM. All four are 0 outside ACCESS.
  - wait_cnt decrements each cycle.
  - On the edge with wait_cnt==0: capture data_read_fDM into the rdata register (reads only; writes leave it unchanged), then go to RESP.
- RESP: lasts one cycle, then IDLE. If owner=AUX, rvalid_AUX=1. No new grant is issued in RESP.
- rdata_MEM and rdata_AUX both present the rdata register and hold it until the next read capture.
- stall_MEM = mem_req && !(state==RESP && owner==MEM) (combinational).
- Timing: a MEM request first seen in IDLE at cycle 0 is in ACCESS for cycles 1..MEM_LATENCY, in RESP at cycle MEM_LATENCY+1, and stall_MEM=0 from that cycle.
  - Back-to-back MEM ops are re-arbitrated in the IDLE cycle that follows RESP.
  - Throughput is one access per MEM_LATENCY+2 cycles.
- Request drops during ACCESS (e.g. pipeline flush): the access is not aborted and runs to RESP.
- AUX requests during ACCESS/RESP remain pending and never see gnt_AUX outside IDLE.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds ports perf_stall_cnt (out 32) and perf_aux_cnt (out 32).
  - perf_stall_cnt increments each cycle stall_MEM=1.
  - perf_aux_cnt increments on each gnt_AUX.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=4):
- MEM load, addr_MEM=0x100, data_read_fDM=0xDEADBEEF: MemRead_2DM=1 in cycles 1-2 with address 0x100; stall_MEM=1 in cycles 0-2 and 0 in cycle 3; rdata_MEM=0xDEADBEEF in cycle 3.
- MEM store, addr 0x40, wdata 0x12345678: MemWrite_2DM=1 with data_write_2DM=0x12345678 for 2 cycles; rdata_MEM unchanged; MemRead_2DM stays 0.
- req_AUX read of 0x80 while MEM idle: gnt_AUX pulses in cycle 0 and rvalid_AUX in cycle 3; stall_MEM stays 0 throughout.
- mem_req held continuously (5 back-to-back ops) with req_AUX=1: MEM is granted 4 times, then AUX is granted on the 5th arbitration; starve_cnt then returns to 0.
- Drive RESET=0 in cycle 1 of an ACCESS: all outputs 0 immediately; no RESP/rvalid_AUX pulse; the next request after release starts fresh from IDLE.
- With DMEM_ARB_PERF_EN defined, run the first scenario twice: perf_stall_cnt=6 and perf_aux_cnt=0.
